// File: rtl/logicnets_pkg.sv
// logicnets_pkg: shared FSM state type and sample quantizer for the LogicNets input path.
//   state_t  : FILL (accumulating features) / WAIT (vector complete, output register busy)
//   quantize : arithmetic right shift followed by saturation to a signed fw-bit range
package logicnets_pkg;

    typedef enum logic {FILL, WAIT} state_t;

    function automatic int quantize(input int x, input int shift, input int fw);
        int s, hi, lo;
        s  = x >>> shift;
        hi = (1 << (fw - 1)) - 1;
        lo = -(1 << (fw - 1));
        return (s > hi) ? hi : ((s < lo) ? lo : s);
    endfunction

endpackage

// File: rtl/logicnets_quant.sv
// logicnets_quant: combinational quantizer, one raw sample to one saturated feature.
//   i_x : signed raw sample (IN_W bits)
//   o_q : two's complement feature (FEAT_W bits)
module logicnets_quant
    import logicnets_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int FEAT_W = 2,
    parameter int SHIFT  = 5
) (
    input  logic signed [IN_W-1:0]   i_x,
    output logic        [FEAT_W-1:0] o_q
);

    assign o_q = FEAT_W'(quantize(int'(i_x), SHIFT, FEAT_W));

endmodule

// File: rtl/logicnets_input_packer.sv
// logicnets_input_packer: packs a stream of quantized samples into N_FEAT-wide feature vectors.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last : sample stream; in_last marks the final sample of a vector
//   out_valid/out_ready/out_data    : packed vector, feature i at out_data[i*FEAT_W +: FEAT_W]
//   err_short/err_long              : sticky flags for vectors ended early by in_last / overrun
module logicnets_input_packer
    import logicnets_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int FEAT_W = 2,
    parameter int SHIFT  = 5,
    parameter int N_FEAT = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_W-1:0]     in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_FEAT*FEAT_W-1:0]   out_data,
    output logic                       err_short,
    output logic                       err_long
);

    localparam int CNT_W = $clog2(N_FEAT + 1);
    localparam int VW    = N_FEAT * FEAT_W;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [VW-1:0]    r_acc, w_acc_nxt, r_odata;
    logic             r_rdy, r_ovalid, r_err_s, r_err_l;
    logic [FEAT_W-1:0] w_q;
    logic             w_fire, w_full, w_end, w_free, w_load;

    logicnets_quant #(.IN_W(IN_W), .FEAT_W(FEAT_W), .SHIFT(SHIFT)) u_quant (
        .i_x (in_data),
        .o_q (w_q)
    );

    // r_rdy keeps in_ready low while reset is held and until the first edge after release
    assign in_ready  = r_rdy && (r_state == FILL);
    assign out_valid = r_ovalid;
    assign out_data  = r_odata;
    assign err_short = r_err_s;
    assign err_long  = r_err_l;

    assign w_fire = in_valid && in_ready;
    assign w_full = (r_cnt == CNT_W'(N_FEAT - 1));
    assign w_end  = w_fire && (in_last || w_full);
    assign w_free = !r_ovalid || out_ready;
    // the output register loads either straight from the finishing beat or from a parked vector
    assign w_load = (w_end && w_free) || (r_state == WAIT && out_ready);

    // accumulator with the incoming feature merged into its slot; unchanged while parked in WAIT
    always_comb begin
        w_acc_nxt = r_acc;
        for (int i = 0; i < N_FEAT; i++)
            if (w_fire && r_cnt == CNT_W'(i)) w_acc_nxt[i*FEAT_W +: FEAT_W] = w_q;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == FILL && w_end && !w_free) w_state_nxt = WAIT;
        else if (r_state == WAIT && out_ready)   w_state_nxt = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_ovalid <= 1'b0;
            r_odata  <= '0;
            r_err_s  <= 1'b0;
            r_err_l  <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_load) begin
                r_odata  <= w_acc_nxt;
                r_ovalid <= 1'b1;
            end else if (out_ready) begin
                r_ovalid <= 1'b0;
            end
            // a completed vector that cannot load stays in r_acc until WAIT drains it
            if (w_load) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_fire) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_end ? '0 : r_cnt + 1'b1;
            end
            if (w_end) begin
                r_err_s <= r_err_s | (in_last && !w_full);
                r_err_l <= r_err_l | (!in_last && w_full);
            end
        end
    end

endmodule

// File: tb/tb_logicnets_input_packer.sv
// tb_logicnets_input_packer: directed stimulus with a queue-based reference model and literal checks.
module tb_logicnets_input_packer;

    localparam int N  = 32;
    localparam int FW = 2;
    localparam int VW = N * FW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, out_valid, err_short, err_long;
    logic [VW-1:0] out_data;

    int n_pass = 0;
    int n_chk  = 0;

    logicnets_input_packer #(.IN_W(8), .FEAT_W(FW), .SHIFT(5), .N_FEAT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_short (err_short),
        .err_long  (err_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // floor(x / 32) clamped to [-2, 1], returned as a 2-bit two's complement code
    function automatic logic [1:0] mq(input logic [7:0] b);
        int v, s;
        v = int'($signed(b));
        s = (v < 0) ? -((-v + 31) / 32) : v / 32;
        if (s > 1)  s = 1;
        if (s < -2) s = -2;
        return s[1:0];
    endfunction

    logic [VW-1:0] m_q[$];
    logic [VW-1:0] m_acc = '0;
    logic [VW-1:0] d_prev = '0;
    int            m_cnt = 0;
    logic          m_es = 1'b0, m_el = 1'b0, h_prev = 1'b0;

    // reference model and per-cycle compare; handshakes seen here complete at the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_acc  = '0;
            m_cnt  = 0;
            m_es   = 1'b0;
            m_el   = 1'b0;
            h_prev = 1'b0;
        end else begin
            check("err_short", VW'(err_short), VW'(m_es));
            check("err_long", VW'(err_long), VW'(m_el));
            if (h_prev) begin
                check("hold_valid", VW'(out_valid), VW'(1));
                check("hold_data", out_data, d_prev);
            end
            if (out_valid && out_ready) begin
                if (m_q.size() == 0) check("spurious_vector", VW'(out_valid), VW'(0));
                else check("vector", out_data, m_q.pop_front());
            end
            h_prev = out_valid && !out_ready;
            d_prev = out_data;
            if (in_valid && in_ready) begin
                m_acc[m_cnt*FW +: FW] = mq(in_data);
                m_cnt++;
                if (in_last || m_cnt == N) begin
                    if (in_last && m_cnt < N)   m_es = 1'b1;
                    if (!in_last && m_cnt == N) m_el = 1'b1;
                    m_q.push_back(m_acc);
                    m_acc = '0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) check("accept_timeout", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [7:0] qin[4]  = '{8'h7F, 8'h80, 8'h20, 8'hE0};
    logic [1:0] qexp[4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    logic [7:0] pat[4]  = '{8'h00, 8'h20, 8'h80, 8'hE0};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_out_data", out_data, '0);
        check("rst_err_short", VW'(err_short), VW'(0));
        check("rst_err_long", VW'(err_long), VW'(0));
        check("rst_in_ready", VW'(in_ready), VW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", VW'(in_ready), VW'(1));

        out_ready = 1'b1;
        for (int i = 0; i < N; i++) send(8'h20, i == N - 1);
        check("full_latency", VW'(out_valid), VW'(1));
        check("full_data", out_data, {32{2'b01}});
        check("full_err_short", VW'(err_short), VW'(0));
        check("full_err_long", VW'(err_long), VW'(0));

        for (int k = 0; k < 4; k++) begin
            send(qin[k], 1'b1);
            check("quant_valid", VW'(out_valid), VW'(1));
            check("quant_data", out_data, VW'(qexp[k]));
        end
        check("quant_err_short", VW'(err_short), VW'(1));

        send(8'hE0, 1'b0);
        send(8'h20, 1'b0);
        send(8'h80, 1'b1);
        check("short_data", out_data, VW'(6'b10_01_11));

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) send(pat[i % 4], i == N - 1);
        check("bp_a_valid", VW'(out_valid), VW'(1));
        check("bp_a_data", out_data, {8{8'hE4}});
        for (int i = 0; i < N; i++) send(pat[3 - i % 4], i == N - 1);
        check("bp_wait_in_ready", VW'(in_ready), VW'(0));
        check("bp_a_hold", out_data, {8{8'hE4}});
        repeat (3) @(posedge clk);
        #1;
        check("bp_wait_in_ready_late", VW'(in_ready), VW'(0));
        check("bp_a_hold_late", out_data, {8{8'hE4}});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_b_valid", VW'(out_valid), VW'(1));
        check("bp_b_data", out_data, {8{8'h1B}});
        @(posedge clk);
        #1;
        check("bp_drained_valid", VW'(out_valid), VW'(0));
        check("bp_in_ready_back", VW'(in_ready), VW'(1));

        for (int i = 0; i < N; i++) send(8'h20, 1'b0);
        check("long_valid", VW'(out_valid), VW'(1));
        check("long_data", out_data, {32{2'b01}});
        check("long_err_long", VW'(err_long), VW'(1));
        send(8'hE0, 1'b0);
        send(8'h20, 1'b1);
        check("long_next_data", out_data, VW'(4'b01_11));

        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) send(8'h20, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", VW'(out_valid), VW'(0));
        check("mid_rst_data", out_data, '0);
        check("mid_rst_err_short", VW'(err_short), VW'(0));
        check("mid_rst_err_long", VW'(err_long), VW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_ghost_vector", VW'(out_valid), VW'(0));
        end
        for (int i = 0; i < N; i++) send(8'hE0, i == N - 1);
        check("post_rst_valid", VW'(out_valid), VW'(1));
        check("post_rst_data", out_data, {VW{1'b1}});
        check("post_rst_err_short", VW'(err_short), VW'(0));
        check("post_rst_err_long", VW'(err_long), VW'(0));
        @(posedge clk);
        #1;
        check("model_drained", VW'(m_q.size()), VW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/logicnets_input_packer.md
LOGICNETS_INPUT_PACKER -- requirements
Module: logicnets_input_packer

Interface
REQ-001 SHALL have parameter IN_W, default 8, width of each raw signed input sample.
REQ-002 SHALL have parameter FEAT_W, default 2, width of each quantized signed feature.
REQ-003 SHALL have parameter SHIFT, default 5, arithmetic right-shift applied before saturation.
REQ-004 SHALL have parameter N_FEAT, default 32, number of features per packed vector.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, IN_W, signed sample) and in_last (input, 1, final sample of a vector).
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, N_FEAT*FEAT_W, packed vector for the first neuron layer).
REQ-009 SHALL have ports err_short and err_long (output, 1 each, sticky error flags).

Function
REQ-010 SHALL quantize each accepted sample as q = saturate(in_data >>> SHIFT) to the signed FEAT_W range [-2^(FEAT_W-1), 2^(FEAT_W-1)-1], two's complement.
REQ-011 SHALL place feature i (i = 0 is the first sample accepted after a vector boundary) at out_data[i*FEAT_W +: FEAT_W].
REQ-012 SHALL accept an input beat only when in_valid and in_ready are both high, at a sustained rate of one beat per cycle.
REQ-013 SHALL keep an accumulator register and a feature counter of width clog2(N_FEAT+1), plus a separate output register, giving double buffering.
REQ-014 SHALL use states FILL (accumulating), WAIT (vector complete, output register occupied) and nothing else; reset enters FILL.
REQ-015 SHALL complete a vector on the beat that has in_last=1 or that brings the counter to N_FEAT, whichever comes first.
REQ-016 SHALL transfer a completed vector to the output register on the cycle after its final beat when out_valid is low or out_ready is high that cycle; otherwise it SHALL enter WAIT.
REQ-017 SHALL, in WAIT, drive in_ready low and transfer the vector on the first cycle with out_ready high, then return to FILL with the counter at 0.
REQ-018 SHALL drive in_ready high in FILL, including on the cycle a completed vector is transferred.
REQ-019 SHALL give a latency of one cycle from acceptance of the final beat to out_valid high, when the output register is free.
REQ-020 SHALL hold out_valid and out_data stable until out_ready is sampled high, and SHALL drop out_valid after the handshake unless a new vector loads that same cycle.
REQ-021 SHALL zero-fill unreceived feature slots when in_last ends a vector with fewer than N_FEAT beats, and SHALL set err_short.
REQ-022 SHALL emit the vector when the counter reaches N_FEAT without in_last, SHALL set err_long, and SHALL start a new vector with the next beat.
REQ-023 SHALL clear the accumulator to zero on every vector boundary, so stale features never leak into the next vector.

Reset
REQ-024 SHALL on rst_n low asynchronously force: state FILL, counter 0, accumulator 0, out_valid 0, out_data 0, err_short 0, err_long 0.
REQ-025 SHALL drive in_ready high from the first clock edge after rst_n deasserts.
REQ-026 SHALL discard a partially filled vector if reset is asserted mid-vector; no output SHALL result from it.
REQ-027 SHALL clear err_short and err_long only by reset.

Structure
REQ-028 SHALL place the state enum and the quantize/saturate function in the shared logicnets_pkg package.
REQ-029 SHALL implement quantization as one sub-module, logicnets_quant, that is purely combinational.

Verification
REQ-030 Saturation check with IN_W=8, SHIFT=5, FEAT_W=2: inputs 0x7F, 0x80, 0x20, 0xE0 -> 2'b01, 2'b10, 2'b01, 2'b11.
REQ-031 Full vector check: 32 beats of 0x20 with in_last on beat 32 and out_ready=1 -> out_valid on the next cycle, out_data = {32{2'b01}}, no error flags set.
REQ-032 Short vector check: 3 beats (0xE0, 0x20, 0x80) with in_last on beat 3 -> out_data[5:0] = 6'b10_01_11, upper bits 0, err_short=1.
REQ-033 Backpressure check: out_ready=0 while two vectors are streamed -> first vector is held stable, in_ready goes low after the second completes, and out_ready=1 drains both in order.
REQ-034 Long vector check: 33 beats with no in_last -> one vector after beat 32, err_long=1, and beat 33 lands in slot 0 of the next vector.
REQ-035 Reset check: assert rst_n low after beat 10 of a vector -> all outputs reach their reset values at once, and a following 32-beat vector is emitted clean.
